// File: rtl/hack_pkg.sv
// Shared constants and FSM encoding for the Hack arithmetic blocks.
package hack_pkg;

  localparam int unsigned HACK_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hack_sub16_serial_fullsub.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module hack_fullsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow propagation for a single column
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/hack_sub16_serial.sv
// Bit-serial subtractor: out = a - b, one bit per clock, LSB first, through a
// single full-subtractor cell. Result and flags hold until the next DONE.
module hack_sub16_serial
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             zr,
  output logic             ng
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
  logic [WIDTH-1:0] res_next;
  logic [CntW-1:0]  cnt_q;
  logic             br_q;
  logic [WIDTH-1:0] out_q;
  logic             borrow_q, zr_q, ng_q;
  logic             cell_d, cell_bout;
  logic             accept, last_bit;

  hack_fullsub u_fullsub (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign accept   = start & ready;
  assign last_bit = (state_q == RUN) && (cnt_q == CntLast);
  // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the first one
  assign res_next = {cell_d, res_sh_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Operand shift, borrow chain, bit counter and result/flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      zr_q     <= 1'b1;
      ng_q     <= 1'b0;
    end else if (accept) begin
      a_sh_q <= a;
      b_sh_q <= b;
      cnt_q  <= '0;
      br_q   <= 1'b0;
    end else if (state_q == RUN) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      res_sh_q <= res_next;
      br_q     <= cell_bout;
      cnt_q    <= cnt_q + CntW'(1);
      // Visible result only changes when the final bit lands
      if (last_bit) begin
        out_q    <= res_next;
        borrow_q <= cell_bout;
        zr_q     <= (res_next == '0);
        ng_q     <= res_next[WIDTH-1];
      end
    end
  end

  assign out    = out_q;
  assign borrow = borrow_q;
  assign zr     = zr_q;
  assign ng     = ng_q;

endmodule

// File: tb/tb_hack_sub16_serial.sv
// Self-checking bench for hack_sub16_serial: a transaction-level model tracks
// when results are due and what they must be; literal vectors pin the model.
module tb_hack_sub16_serial;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready, busy, done, borrow, zr, ng;
  logic [W-1:0]  out;

  int checks = 0;
  int errors = 0;

  hack_sub16_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .borrow (borrow),
    .zr     (zr),
    .ng     (ng)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: rem counts edges until the result is due; 0 means ready to accept.
  int            rem = 0;
  bit            m_valid = 1'b0;
  bit            m_done = 1'b0;
  logic [W-1:0]  m_out = '0;
  bit            m_borrow = 1'b0;
  logic [W-1:0]  pa, pb;

  always @(posedge clk) begin
    if (!rst_n) begin
      rem      = 0;
      m_done   = 1'b0;
      m_out    = '0;
      m_borrow = 1'b0;
      m_valid  = 1'b1;
    end else begin
      m_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_done   = 1'b1;
          m_out    = pa - pb;
          m_borrow = (pa < pb);
        end
      end else if (start) begin
        pa  = a;
        pb  = b;
        rem = W;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready",  32'(ready),  32'(rem == 0));
      check("busy",   32'(busy),   32'(rem > 0));
      check("done",   32'(done),   32'(m_done));
      check("out",    32'(out),    32'(m_out));
      check("borrow", 32'(borrow), 32'(m_borrow));
      check("zr",     32'(zr),     32'(m_out == '0));
      check("ng",     32'(ng),     32'(m_out[W-1]));
    end
  end

  // Count negedges until done; start is cleared (or scrambled) after the first.
  task automatic wait_done(input bit disturb, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (disturb && n < 12) begin
        a     = W'($urandom);
        b     = W'($urandom);
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end while (!done && n < 60);
  endtask

  task automatic check_res(input string name, input logic [W-1:0] eo, input bit eb);
    check({name, "_out"},    32'(out),    32'(eo));
    check({name, "_borrow"}, 32'(borrow), 32'(eb));
    check({name, "_zr"},     32'(zr),     32'(eo == '0));
    check({name, "_ng"},     32'(ng),     32'(eo[W-1]));
    check({name, "_model"},  32'(m_out),  32'(eo));
  endtask

  // Launch from a negedge; latency count includes the accepting edge
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] eo, input bit eb, input bit disturb);
    int n;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    wait_done(disturb, n);
    check({name, "_latency"}, 32'(n), 32'(W + 1));
    check_res(name, eo, eb);
  endtask

  initial begin
    int n;
    int dones;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_out",    32'(out),    32'h0);
    check("rst_zr",     32'(zr),     32'd1);
    check("rst_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;

    run_op("zero",   16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("z_m_f",  16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    run_op("f_m_f",  16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    run_op("aaaa",   16'hAAAA, 16'h5555, 16'h5555, 1'b0, 1'b0);
    run_op("3cc3",   16'h3CC3, 16'h0FF0, 16'h2CD3, 1'b0, 1'b0);
    run_op("1234",   16'h1234, 16'h9876, 16'h79BE, 1'b1, 1'b1);

    // Back-to-back: start held in the DONE cycle
    a     = 16'h8000;
    b     = 16'h0001;
    start = 1'b1;
    wait_done(1'b0, n);
    check("b2b_latency", 32'(n), 32'd17);
    check_res("b2b", 16'h7FFF, 1'b0);

    // Reset in the middle of RUN
    @(negedge clk);
    a     = 16'h4321;
    b     = 16'h0123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_out",   32'(out),   32'h0);
    check("abort_zr",    32'(zr),    32'd1);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op("fresh", 16'h4321, 16'h0123, 16'h41FE, 1'b0, 1'b0);

    // Randomized operations, some back-to-back, some disturbed during RUN
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ra;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a     = ra;
      b     = rb;
      start = 1'b1;
      wait_done(1'($urandom_range(0, 1)), n);
      check("rand_latency", 32'(n), 32'(W + 1));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
